seconds_timer_ctrl: RTL and testbench
=====================================

Name: seconds_timer_ctrl

Overview:
Consumer of the one-cycle seconds pulse produced by the 100 MHz clock divider. Maintains an MM:SS time value in packed BCD, counting up or down one step per accepted pulse, under start/stop/clear/load control. Drives the display path and flags completion (countdown reached 00:00, or count-up saturated).

Parameters:
MAX_MIN, 99, highest minute value in decimal (1..99); count-up limit is MAX_MIN:59.
WRAP_UP, 1, 1 = count-up wraps MAX_MIN:59 -> 00:00 and keeps running; 0 = saturates and enters DONE.

Ports:
clk_100MHz_i  in  1  system clock, 100 MHz
reset_i  in  1  synchronous, active-high reset
seconds_pulse_i  in  1  one-cycle tick, one per second
start_i  in  1  start/resume request, single-cycle pulse
stop_i  in  1  pause request, single-cycle pulse
clear_i  in  1  return to 00:00 and IDLE
load_i  in  1  load preset from load_min_i/load_sec_i
load_min_i  in  8  preset minutes, packed BCD {tens,units}
load_sec_i  in  8  preset seconds, packed BCD {tens,units}
count_down_i  in  1  direction, sampled on start from IDLE (1 = down)
min_bcd_o  out  8  current minutes, packed BCD
sec_bcd_o  out  8  current seconds, packed BCD
running_o  out  1  high in RUN
done_o  out  1  high in DONE
tick_o  out  1  one-cycle pulse when the time value changed due to a pulse
load_err_o  out  1  one-cycle pulse when a load is rejected as invalid

Behaviour:
- Reset (reset_i high at a clock edge): min/sec = 00:00, state IDLE, direction = up, all 1-bit outputs 0. Reset mid-RUN behaves identically.
- States: IDLE, RUN, PAUSE, DONE. Registered state; outputs decoded from registers.
- Input priority per cycle: clear_i > load_i > stop_i > start_i > seconds_pulse_i.
- clear_i: any state -> IDLE, time 00:00. Direction unchanged.
- load_i: accepted in IDLE, PAUSE and DONE -> time = preset, state -> IDLE. Ignored in RUN (no error). Rejected if any nibble > 9, seconds tens > 5, or minutes > MAX_MIN: time unchanged, load_err_o = 1 next cycle.
- start_i: IDLE -> RUN, latches count_down_i. PAUSE -> RUN, keeps the latched direction. Ignored in RUN and DONE.
- Start from IDLE with down and time 00:00: goes to DONE on the next cycle; never enters RUN.
- stop_i: RUN -> PAUSE; ignored elsewhere.
- A pulse counts only if the state is RUN and no higher-priority input is active in that cycle. Pulse during a start or stop cycle: dropped.
- Latency: accepted pulse at edge N -> new time, and tick_o = 1, visible after edge N (for one cycle).
- Count up: seconds 59 -> 00 with a minute carry.
  - At MAX_MIN:59 with WRAP_UP=1: -> 00:00, stay in RUN.
  - With WRAP_UP=0: time held, state -> DONE, tick_o = 0.
- Count down: seconds 00 -> 59 with a minute borrow. A step that reaches 00:00 sets time 00:00, tick_o = 1, state -> DONE in the same edge.
- DONE: time frozen, pulses ignored; exit only via clear, load or reset.
- BCD arithmetic is per nibble. No binary intermediate wider than 7 bits is exposed.

Decomposition:
- Shared package timer_pkg: state enum (IDLE, RUN, PAUSE, DONE), BCD constants (BCD_ZERO = 8'h00, SEC_MAX = 8'h59), nibble-valid helper function.
- Sub-module bcd_2digit_counter: two-digit BCD counter with inc/dec enable, parameterized modulus, carry/borrow out and terminal flag. Instantiated twice: seconds (mod 60) and minutes (mod MAX_MIN+1).

Test Plan:
- Load 01:30, count_down=1, start, 3 pulses -> 01:27, tick_o pulsed 3 times, running_o = 1; reset during RUN -> 00:00, IDLE, all flags 0.
- Load 01:00, down, 1 pulse -> 00:59. Load 00:01, down, 1 pulse -> 00:00, done_o = 1, running_o = 0. Two more pulses -> still 00:00, no tick_o.
- Load 99:59, up, WRAP_UP=1, 1 pulse -> 00:00, still RUN. Same with WRAP_UP=0 -> 99:59 held, done_o = 1, tick_o = 0.
- Load min 8'h00, sec 8'h6A -> load_err_o one cycle, time unchanged. Load 12:34 while RUN -> ignored, no error.
- In RUN at 00:10 up: stop_i and pulse in the same cycle -> PAUSE, time 00:10. Start (with count_down_i = 1) then 1 pulse -> 00:11 (direction kept as up).
- Start from IDLE at 00:00 with down -> done_o = 1 next cycle, running_o never 1. Clear -> IDLE, 00:00.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types, BCD constants and helpers for the seconds timer controller
// and its BCD digit counters.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } timer_state_e;

    localparam logic [7:0] BCD_ZERO = 8'h00;
    localparam logic [7:0] SEC_MAX  = 8'h59;

    function automatic logic nibble_valid(input logic [3:0] nibble);
        return nibble <= 4'd9;
    endfunction

    // Decimal 0..99 to packed BCD {tens,units}, used only for constants.
    function automatic logic [7:0] to_bcd(input int value);
        return {4'(value / 10), 4'(value % 10)};
    endfunction

endpackage

// File: rtl/bcd_2digit_counter.sv
// Two-digit packed BCD up/down counter with a parameterized modulus.
// Carry/borrow report a wrap on the current step so digits can be chained.
module bcd_2digit_counter
    import timer_pkg::*;
#(
    parameter int MODULUS = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] value,
    output logic       carry,
    output logic       borrow,
    output logic       at_max,
    output logic       at_zero
);

    localparam logic [7:0] MAX_BCD = to_bcd(MODULUS - 1);

    logic [7:0] value_q, value_d;

    assign value   = value_q;
    assign at_max  = (value_q == MAX_BCD);
    assign at_zero = (value_q == BCD_ZERO);
    assign carry   = inc && at_max;
    assign borrow  = dec && at_zero;

    always_comb begin
        value_d = value_q;
        if (inc) begin
            if (at_max)
                value_d = BCD_ZERO;
            else if (value_q[3:0] == 4'd9)
                value_d = {value_q[7:4] + 4'd1, 4'd0};
            else
                value_d = {value_q[7:4], value_q[3:0] + 4'd1};
        end else if (dec) begin
            if (at_zero)
                value_d = MAX_BCD;
            else if (value_q[3:0] == 4'd0)
                value_d = {value_q[7:4] - 4'd1, 4'd9};
            else
                value_d = {value_q[7:4], value_q[3:0] - 4'd1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear)
            value_q <= BCD_ZERO;
        else if (load)
            value_q <= load_value;
        else
            value_q <= value_d;
    end

endmodule

// File: rtl/seconds_timer_ctrl.sv
// MM:SS BCD timer driven by the one-second pulse: start/stop/clear/load
// control, up or down counting, completion and load-error flags.
module seconds_timer_ctrl
    import timer_pkg::*;
#(
    parameter int MAX_MIN = 99,
    parameter bit WRAP_UP = 1'b1
) (
    input  logic       clk_100MHz_i,
    input  logic       reset_i,
    input  logic       seconds_pulse_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       clear_i,
    input  logic       load_i,
    input  logic [7:0] load_min_i,
    input  logic [7:0] load_sec_i,
    input  logic       count_down_i,
    output logic [7:0] min_bcd_o,
    output logic [7:0] sec_bcd_o,
    output logic       running_o,
    output logic       done_o,
    output logic       tick_o,
    output logic       load_err_o
);

    localparam logic [7:0] MIN_MAX_BCD = to_bcd(MAX_MIN);

    timer_state_e state_q, state_d;
    logic count_down_q, count_down_d;
    logic tick_q, tick_d, load_err_q, load_err_d;
    logic ctr_clear, ctr_load, sec_inc, sec_dec;
    logic sec_carry, sec_borrow, sec_at_max, sec_at_zero;
    logic min_carry, min_borrow, min_at_max, min_at_zero;
    logic load_valid, time_zero, up_limit, down_last;
    logic unused_min_flags;

    assign load_valid = nibble_valid(load_min_i[7:4]) && nibble_valid(load_min_i[3:0])
                     && nibble_valid(load_sec_i[3:0]) && (load_sec_i[7:4] <= 4'd5)
                     && (load_min_i <= MIN_MAX_BCD);
    assign time_zero  = min_at_zero && sec_at_zero;
    assign up_limit   = min_at_max && sec_at_max;
    assign down_last  = min_at_zero && (sec_bcd_o == 8'h01);
    assign unused_min_flags = min_carry ^ min_borrow;

    bcd_2digit_counter #(.MODULUS(60)) u_sec (
        .clk(clk_100MHz_i), .reset(reset_i), .clear(ctr_clear), .load(ctr_load),
        .load_value(load_sec_i), .inc(sec_inc), .dec(sec_dec), .value(sec_bcd_o),
        .carry(sec_carry), .borrow(sec_borrow), .at_max(sec_at_max), .at_zero(sec_at_zero)
    );

    bcd_2digit_counter #(.MODULUS(MAX_MIN + 1)) u_min (
        .clk(clk_100MHz_i), .reset(reset_i), .clear(ctr_clear), .load(ctr_load),
        .load_value(load_min_i), .inc(sec_carry), .dec(sec_borrow), .value(min_bcd_o),
        .carry(min_carry), .borrow(min_borrow), .at_max(min_at_max), .at_zero(min_at_zero)
    );

    // The else-if chain encodes input priority: a lower input acts only when no higher one is asserted.
    always_comb begin
        state_d      = state_q;
        count_down_d = count_down_q;
        tick_d       = 1'b0;
        load_err_d   = 1'b0;
        ctr_clear    = 1'b0;
        ctr_load     = 1'b0;
        sec_inc      = 1'b0;
        sec_dec      = 1'b0;
        if (clear_i) begin
            state_d   = IDLE;
            ctr_clear = 1'b1;
        end else if (load_i) begin
            if (state_q != RUN) begin
                if (load_valid) begin
                    ctr_load = 1'b1;
                    state_d  = IDLE;
                end else begin
                    load_err_d = 1'b1;
                end
            end
        end else if (stop_i) begin
            if (state_q == RUN)
                state_d = PAUSE;
        end else if (start_i) begin
            if (state_q == IDLE) begin
                count_down_d = count_down_i;
                state_d      = (count_down_i && time_zero) ? DONE : RUN;
            end else if (state_q == PAUSE) begin
                state_d = RUN;
            end
        end else if (seconds_pulse_i && state_q == RUN) begin
            if (!count_down_q) begin
                if (up_limit && !WRAP_UP) begin
                    state_d = DONE;
                end else begin
                    sec_inc = 1'b1;
                    tick_d  = 1'b1;
                end
            end else if (time_zero) begin
                state_d = DONE;
            end else begin
                sec_dec = 1'b1;
                tick_d  = 1'b1;
                if (down_last)
                    state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk_100MHz_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            count_down_q <= 1'b0;
            tick_q       <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_down_q <= count_down_d;
            tick_q       <= tick_d;
            load_err_q   <= load_err_d;
        end
    end

    assign running_o  = (state_q == RUN);
    assign done_o     = (state_q == DONE);
    assign tick_o     = tick_q;
    assign load_err_o = load_err_q;

endmodule

// File: tb/tb_seconds_timer_ctrl.sv
// Directed bench for seconds_timer_ctrl: one wrapping and one saturating
// instance share stimulus; expected values are hand-computed constants.
module tb_seconds_timer_ctrl;

    logic       clk_100MHz_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       seconds_pulse_i = 1'b0;
    logic       start_i = 1'b0;
    logic       stop_i = 1'b0;
    logic       clear_i = 1'b0;
    logic       load_i = 1'b0;
    logic [7:0] load_min_i = 8'h00;
    logic [7:0] load_sec_i = 8'h00;
    logic       count_down_i = 1'b0;

    logic [7:0] min_a, sec_a, min_b, sec_b;
    logic       run_a, done_a, tick_a, err_a;
    logic       run_b, done_b, tick_b, err_b;

    int compared = 0;
    int mismatched = 0;

    always #5 clk_100MHz_i = ~clk_100MHz_i;

    seconds_timer_ctrl #(.MAX_MIN(99), .WRAP_UP(1'b1)) dut_wrap (
        .clk_100MHz_i(clk_100MHz_i), .reset_i(reset_i), .seconds_pulse_i(seconds_pulse_i),
        .start_i(start_i), .stop_i(stop_i), .clear_i(clear_i), .load_i(load_i),
        .load_min_i(load_min_i), .load_sec_i(load_sec_i), .count_down_i(count_down_i),
        .min_bcd_o(min_a), .sec_bcd_o(sec_a), .running_o(run_a), .done_o(done_a),
        .tick_o(tick_a), .load_err_o(err_a)
    );

    seconds_timer_ctrl #(.MAX_MIN(99), .WRAP_UP(1'b0)) dut_sat (
        .clk_100MHz_i(clk_100MHz_i), .reset_i(reset_i), .seconds_pulse_i(seconds_pulse_i),
        .start_i(start_i), .stop_i(stop_i), .clear_i(clear_i), .load_i(load_i),
        .load_min_i(load_min_i), .load_sec_i(load_sec_i), .count_down_i(count_down_i),
        .min_bcd_o(min_b), .sec_bcd_o(sec_b), .running_o(run_b), .done_o(done_b),
        .tick_o(tick_b), .load_err_o(err_b)
    );

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after a rising edge; outputs are then read 1 ns after the next one.
    task automatic cycle();
        @(posedge clk_100MHz_i);
        #1;
    endtask

    task automatic applyStimulus(input logic clr, input logic ld, input logic stp,
                                 input logic st, input logic pls);
        clear_i = clr; load_i = ld; stop_i = stp; start_i = st; seconds_pulse_i = pls;
        cycle();
        clear_i = 1'b0; load_i = 1'b0; stop_i = 1'b0; start_i = 1'b0; seconds_pulse_i = 1'b0;
    endtask

    task automatic doLoad(input logic [7:0] mm, input logic [7:0] ss);
        load_min_i = mm;
        load_sec_i = ss;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic doStart(input logic down);
        count_down_i = down;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic doPulse();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int ticks;
        cycle();
        cycle();
        reset_i = 1'b0;
        checkOutput("reset_time", {min_a, sec_a}, 16'h0000);
        checkOutput("reset_flags", {12'h0, run_a, done_a, tick_a, err_a}, 16'h0000);

        // Countdown 01:30 for three seconds, then reset mid-run.
        doLoad(8'h01, 8'h30);
        doStart(1'b1);
        ticks = 0;
        for (int i = 0; i < 3; i++) begin
            doPulse();
            if (tick_a) ticks++;
        end
        checkOutput("down3_time", {min_a, sec_a}, 16'h0127);
        checkOutput("down3_ticks", 16'(ticks), 16'd3);
        checkOutput("down3_running", {15'h0, run_a}, 16'h0001);
        cycle();
        checkOutput("tick_one_cycle", {15'h0, tick_a}, 16'h0000);
        reset_i = 1'b1;
        cycle();
        reset_i = 1'b0;
        checkOutput("midrun_reset_time", {min_a, sec_a}, 16'h0000);
        checkOutput("midrun_reset_flags", {12'h0, run_a, done_a, tick_a, err_a}, 16'h0000);

        // Minute borrow, then countdown completion and frozen DONE.
        doLoad(8'h01, 8'h00);
        doStart(1'b1);
        doPulse();
        checkOutput("borrow_time", {min_a, sec_a}, 16'h0059);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        doLoad(8'h00, 8'h01);
        doStart(1'b1);
        doPulse();
        checkOutput("reach_zero_time", {min_a, sec_a}, 16'h0000);
        checkOutput("reach_zero_flags", {13'h0, run_a, done_a, tick_a}, 16'h0003);
        ticks = 0;
        for (int i = 0; i < 2; i++) begin
            doPulse();
            if (tick_a) ticks++;
        end
        checkOutput("done_frozen_time", {min_a, sec_a}, 16'h0000);
        checkOutput("done_no_ticks", 16'(ticks), 16'd0);
        checkOutput("done_held", {15'h0, done_a}, 16'h0001);

        // Count-up limit: wrapping instance vs saturating instance.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        doLoad(8'h99, 8'h59);
        doStart(1'b0);
        doPulse();
        checkOutput("wrap_time", {min_a, sec_a}, 16'h0000);
        checkOutput("wrap_flags", {13'h0, run_a, done_a, tick_a}, 16'h0005);
        checkOutput("sat_time", {min_b, sec_b}, 16'h9959);
        checkOutput("sat_flags", {13'h0, run_b, done_b, tick_b}, 16'h0002);

        // Invalid load in PAUSE, then a load ignored while running.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        doLoad(8'h00, 8'h6A);
        checkOutput("bad_load_err", {15'h0, err_a}, 16'h0001);
        checkOutput("bad_load_time", {min_a, sec_a}, 16'h0000);
        cycle();
        checkOutput("bad_load_err_drop", {15'h0, err_a}, 16'h0000);
        doLoad(8'h7A, 8'h00);
        checkOutput("bad_min_err", {15'h0, err_a}, 16'h0001);
        doStart(1'b1);
        doLoad(8'h12, 8'h34);
        checkOutput("run_load_time", {min_a, sec_a}, 16'h0000);
        checkOutput("run_load_flags", {14'h0, run_a, err_a}, 16'h0002);

        // Stop and start swallow a coincident pulse; resume keeps direction.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        doLoad(8'h00, 8'h10);
        doStart(1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("stop_pulse_time", {min_a, sec_a}, 16'h0010);
        checkOutput("stop_pulse_running", {15'h0, run_a}, 16'h0000);
        count_down_i = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("start_pulse_time", {min_a, sec_a}, 16'h0010);
        doPulse();
        checkOutput("resume_dir_time", {min_a, sec_a}, 16'h0011);

        // Seconds carry into minutes.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        doLoad(8'h00, 8'h59);
        doStart(1'b0);
        doPulse();
        checkOutput("carry_time", {min_a, sec_a}, 16'h0100);

        // Down start at 00:00 goes straight to DONE; clear returns to IDLE.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        doStart(1'b1);
        checkOutput("zero_start_flags", {14'h0, run_a, done_a}, 16'h0001);
        cycle();
        checkOutput("zero_start_still", {14'h0, run_a, done_a}, 16'h0001);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("clear_time", {min_a, sec_a}, 16'h0000);
        checkOutput("clear_flags", {14'h0, run_a, done_a}, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
